// File: rtl/float_mul_requester_pkg.sv
// ---------------------------------------------------------------------------
// float_mul_requester_pkg
// Shared types and sizing helpers for the float multiplier requester.
//   req_state_t   : handshake FSM states (IDLE, REQ, RELEASE)
//   timer_width() : bits needed for a phase timer counting to a given limit
//   TIMER_W       : timer width for the default 35-cycle phase limit
// ---------------------------------------------------------------------------
package float_mul_requester_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } req_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 35;

  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int TIMER_W = timer_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/float_mul_requester_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Cycle counter shared by the REQ and RELEASE handshake phases.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   clear   : restart the count at zero (has priority over enable)
//   enable  : advance the count by one
//   expired : count has reached timeout_cycles-1
// The count parks at the limit so a late clear never sees a wrapped value.
// ---------------------------------------------------------------------------
module phase_timer
  import float_mul_requester_pkg::*;
#(
  parameter int timeout_cycles = DEFAULT_TIMEOUT_CYCLES,
  parameter int timer_w        = TIMER_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [timer_w-1:0] last_count = timer_w'(timeout_cycles - 1);

  logic [timer_w-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + timer_w'(1);
    end
  end

  assign expired = (count == last_count);

endmodule

// File: rtl/float_mul_requester.sv
// ---------------------------------------------------------------------------
// float_mul_requester
// Initiator side of the four-phase req/ack handshake to the pipelined float
// multiplier. Takes operand pairs from an upstream valid/ready stream, holds
// them on mul_a/mul_b while req is high, captures mul_out on ack and offers
// the product on a downstream valid/ready stream. A stuck multiplier is
// escaped with a per-phase timeout that sets a sticky error flag.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : upstream operand handshake
//   in_a, in_b             : upstream operands
//   req/ack                : four-phase handshake with the multiplier
//   mul_a, mul_b           : registered operands to the multiplier
//   mul_out                : multiplier result, valid while ack=1
//   out_valid/out_ready    : downstream result handshake
//   out_result             : captured product
//   timeout_err            : sticky, set when a handshake phase is aborted
//   done_count             : products captured, modulo 2^count_width
// ---------------------------------------------------------------------------
module float_mul_requester
  import float_mul_requester_pkg::*;
#(
  parameter int float_width    = 32,
  parameter int timeout_cycles = 35,
  parameter int count_width    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_width-1:0] in_a,
  input  logic [float_width-1:0] in_b,
  output logic                   req,
  input  logic                   ack,
  output logic [float_width-1:0] mul_a,
  output logic [float_width-1:0] mul_b,
  input  logic [float_width-1:0] mul_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_width-1:0] out_result,
  output logic                   timeout_err,
  output logic [count_width-1:0] done_count
);

  localparam int timer_w = timer_width(timeout_cycles);

  req_state_t state;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;

  // A new pair is only taken when idle and the result slot is empty, so a
  // capture can never overwrite an unconsumed product.
  assign in_ready = (state == IDLE) && !out_valid;

  // The timer restarts on every phase entry: held clear in IDLE, and cleared
  // on the edge that leaves REQ or RELEASE so the next phase starts at zero.
  always_comb begin
    timer_clear  = 1'b1;
    timer_enable = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clear = 1'b1;
      end
      REQ: begin
        timer_clear  = ack || timer_expired;
        timer_enable = 1'b1;
      end
      RELEASE: begin
        timer_clear  = !ack || timer_expired;
        timer_enable = 1'b1;
      end
      default: begin
        timer_clear = 1'b1;
      end
    endcase
  end

  phase_timer #(
    .timeout_cycles(timeout_cycles),
    .timer_w       (timer_w)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      timeout_err <= 1'b0;
      done_count  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          // ack is deliberately ignored here; only a fresh accept moves on
          if (in_valid && in_ready) begin
            mul_a <= in_a;
            mul_b <= in_b;
            req   <= 1'b1;
            state <= REQ;
          end
        end

        REQ: begin
          if (ack) begin
            out_result <= mul_out;
            out_valid  <= 1'b1;
            done_count <= done_count + count_width'(1);
            req        <= 1'b0;
            state      <= RELEASE;
          end else if (timer_expired) begin
            // abort: drop req without producing a result
            req         <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          if (!ack) begin
            state <= IDLE;
          end else if (timer_expired) begin
            // ack stuck high: give up on the return-to-zero and carry on
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operands must not move while the multiplier is being asked.
  operands_stable_during_req : assert property (
    @(posedge clk) disable iff (rst)
      req |=> (!req || ($stable(mul_a) && $stable(mul_b)))
  );

  // The result slot is never refilled while it still holds a product.
  no_accept_when_full : assert property (
    @(posedge clk) disable iff (rst)
      out_valid |-> !in_ready
  );

endmodule

// File: doc/float_mul_requester.md
# float_mul_requester

Initiator side of the four-phase `req`/`ack` handshake used by the pipelined float multiplier. Accepts operand pairs from an upstream valid/ready stream and holds them stable on the multiplier inputs while driving `req`. Captures the product on `ack` and presents it on a downstream valid/ready stream. Sits between the shader-core operand path and `float_mul_pipeline`, and guards against a stuck unit with a bounded timeout.

## Interface
Parameters:
- `float_width`, 32: IEEE-754 word width for operands and result.
- `timeout_cycles`, 35: maximum cycles allowed in a single handshake phase before it is aborted.
- `count_width`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`, `in_b`  in  float_width  upstream operands.
- `req`  out  1  request to the multiplier.
- `ack`  in  1  acknowledge from the multiplier.
- `mul_a`, `mul_b`  out  float_width  operands to the multiplier; registered.
- `mul_out`  in  float_width  multiplier result; valid while `ack`=1.
- `out_valid`  out  1  result register holds an unconsumed product.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  float_width  captured product.
- `timeout_err`  out  1  sticky flag, set by a handshake abort.
- `done_count`  out  count_width  number of products captured; wraps on overflow.

## Operation
- States: `IDLE`, `REQ`, `RELEASE`.
- `in_ready` = (state==`IDLE`) & ~`out_valid`. Only one operation is in flight, and a product is never captured while the result slot is full.
- **`IDLE`:**
  - On `in_valid & in_ready`, latch `in_a`/`in_b` into `mul_a`/`mul_b`, set `req`=1, clear the phase timer, and go to `REQ`.
- **`REQ`:**
  - `req` and `mul_a`/`mul_b` stay stable. The phase timer increments each cycle.
  - If `ack`=1 is sampled: load `out_result` from `mul_out`, set `out_valid`=1, increment `done_count`, set `req`=0, clear the timer, and go to `RELEASE`.
  - Else, if the timer reaches `timeout_cycles`-1: set `req`=0 and `timeout_err`=1, clear the timer, and go to `RELEASE`. No result is produced and `done_count` is unchanged.
- **`RELEASE`:**
  - `req`=0. Wait for `ack`=0, then go to `IDLE`.
  - If `ack` stays high for `timeout_cycles` cycles: set `timeout_err`=1 and go to `IDLE` anyway.
- **Result slot:**
  - `out_valid` clears on `out_valid & out_ready`.
  - `out_result` holds its value until the next capture.
- **`timeout_err`:** clears only on reset.
- **`done_count`:** arithmetic is modulo 2^count_width.
- **Ignored inputs:** `ack` seen in `IDLE` is ignored. `mul_out` is sampled only on the `REQ`→`RELEASE` capture edge.

## Timing
- **Reset values:** `req`=0, `in_ready`=1 (state `IDLE`, slot empty), `out_valid`=0, `out_result`=0, `mul_a`=`mul_b`=0, `timeout_err`=0, `done_count`=0, timer=0.
- **Reset mid-operation:** reset is asynchronous, so `req` drops in the same cycle `rst` rises. The in-flight operation is discarded.
- **Acceptance:** an accept on edge N makes `req`=1 visible from cycle N+1.
- **Capture:** `ack` sampled high on edge M gives `out_valid`=1 and `req`=0 from cycle M+1.
- **Latency:** accept to `out_valid` = multiplier ack latency + 1 cycle.
- **Back-to-back operations:**
  - The earliest next accept is the cycle after `ack` is seen low in `RELEASE` with the slot empty.
  - A result consumed on the same edge that `IDLE` is entered allows acceptance on the following cycle.
- **Timeout:** if `ack` is never seen, `req` falls after exactly `timeout_cycles` cycles high.

## Structure
- Package `float_mul_requester_pkg` holds:
  - the state enum `req_state_t` (`IDLE`, `REQ`, `RELEASE`);
  - a localparam for the timer width, $clog2(`timeout_cycles`+1).
- Sub-module `phase_timer` has inputs `clk`, `rst`, `clear`, `enable` and output `expired` (asserted when count = `timeout_cycles`-1). It is shared by the `REQ` and `RELEASE` phases.

## Test plan
- **Single multiply:** after reset, with a multiplier stub acking 3 cycles after `req`, send `in_a`=0x40000000 and `in_b`=0x40133333 (2.0 × 2.3). Required: `out_result`≈0x40933333 (4.6), `out_valid` one cycle after `ack`, `done_count`=1, `req` low after capture.
- **Zero operand:** `in_a`=0x00000000, `in_b`=0x3F800000. Required: `out_result`=0x00000000 and `timeout_err`=0.
- **Back-pressure:** hold `out_ready`=0 after a 1.0 × 1.0 product. Required:
  - `out_result`=0x3F800000 holds and `in_ready`=0 for 10 cycles;
  - raising `out_ready` clears `out_valid`;
  - `in_ready` returns to 1 the next cycle.
- **Timeout:** the stub never acks. Required: `req` high for exactly 35 cycles, then `timeout_err`=1, `out_valid`=0, `done_count` unchanged, and return to `IDLE` once `ack`=0.
- **Reset mid-request:** assert `rst` 2 cycles into `REQ`. Required: `req`=0 in the same cycle, all outputs at reset values, and the next operation completes normally.
- **Stream and counter wrap:** run 20 random-operand pairs with sign mixes, e.g. -2000.0 × 2.3 → ≈-4600.0 (0xC58FC000). Required:
  - results match in order;
  - `done_count` =20;
  - a separate run with `count_width`=4 wraps 15→0.
